// File: rtl/fourstate_bus_resolver.sv
// Resolves NDRV 4-state tristate drivers per bit under tri/wand/wor and
// presents the result through a PIPE-deep registered pipeline with contention tracking.
module fourstate_bus_resolver #(
  parameter int W    = 4,
  parameter int NDRV = 2,
  parameter int PIPE = 1,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        mode,
  input  logic [NDRV*W-1:0] drv_d_b1,
  input  logic [NDRV*W-1:0] drv_d_b0,
  input  logic [NDRV-1:0]   drv_en_b1,
  input  logic [NDRV-1:0]   drv_en_b0,
  input  logic              clr_cnt,
  output logic              out_valid,
  output logic [W-1:0]      out_b1,
  output logic [W-1:0]      out_b0,
  output logic              conflict,
  output logic [CNTW-1:0]   conflict_cnt
);
  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] VZ = 2'b10;
  localparam logic [1:0] VX = 2'b11;
  localparam int SW = 2 * W + 2;
  localparam logic [SW-1:0]   RST_WORD = {1'b0, {W{1'b1}}, {W{1'b0}}, 1'b0};
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  function automatic logic [1:0] drive(input logic [1:0] en, input logic [1:0] d);
    logic [1:0] r;
    case (en)
      V0:      r = VZ;
      V1:      r = (d[1] == 1'b0) ? d : VX;
      default: r = VX;
    endcase
    return r;
  endfunction

  // Returns {contention on this bit, resolved value}; only tri-like modes flag contention.
  function automatic logic [2:0] resolve(input logic [1:0] md,
                                         input logic [NDRV-1:0] en_b1,
                                         input logic [NDRV-1:0] en_b0,
                                         input logic [NDRV*W-1:0] d_b1,
                                         input logic [NDRV*W-1:0] d_b0,
                                         input int i);
    logic       any0;
    logic       any1;
    logic       anyx;
    logic [1:0] c;
    logic [1:0] r;
    any0 = 1'b0;
    any1 = 1'b0;
    anyx = 1'b0;
    for (int k = 0; k < NDRV; k++) begin
      c    = drive({en_b1[k], en_b0[k]}, {d_b1[k*W+i], d_b0[k*W+i]});
      any0 = any0 | (c == V0);
      any1 = any1 | (c == V1);
      anyx = anyx | (c == VX);
    end
    case (md)
      2'b01:   r = any0 ? V0 : (anyx ? VX : (any1 ? V1 : VZ));
      2'b10:   r = any1 ? V1 : (anyx ? VX : (any0 ? V0 : VZ));
      default: r = (anyx || (any0 && any1)) ? VX : (any0 ? V0 : (any1 ? V1 : VZ));
    endcase
    return {(md != 2'b01) && (md != 2'b10) && any0 && any1, r};
  endfunction

  logic [W-1:0]            res_b1;
  logic [W-1:0]            res_b0;
  logic                    hit;
  logic [2:0]              bit_r;
  logic [SW-1:0]           in_word;
  logic [(PIPE+1)*SW-1:0]  shift_w;
  logic [PIPE*SW-1:0]      pipe_d;
  logic [PIPE*SW-1:0]      pipe_q;
  logic [SW-1:0]           top_w;
  logic [CNTW-1:0]         cnt_d;
  logic [CNTW-1:0]         cnt_q;

  // Per-bit resolution of the incoming sample and the next pipeline contents.
  always_comb begin
    res_b1 = '0;
    res_b0 = '0;
    hit    = 1'b0;
    bit_r  = 3'b000;
    for (int i = 0; i < W; i++) begin
      bit_r     = resolve(mode, drv_en_b1, drv_en_b0, drv_d_b1, drv_d_b0, i);
      res_b1[i] = bit_r[1];
      res_b0[i] = bit_r[0];
      hit       = hit | bit_r[2];
    end
    in_word = {in_valid, res_b1, res_b0, in_valid & hit};
    shift_w = {pipe_q, in_word};
    pipe_d  = shift_w[PIPE*SW-1:0];
  end

  assign top_w        = pipe_q[PIPE*SW-1 -: SW];
  assign out_valid    = top_w[SW-1];
  assign out_b1       = top_w[SW-2 -: W];
  assign out_b0       = top_w[W:1];
  assign conflict     = top_w[0];
  assign conflict_cnt = cnt_q;

  // Saturating contention counter fed by the presented sample; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (top_w[SW-1] && top_w[0] && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNTW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset flushes every stage and the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= {PIPE{RST_WORD}};
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fourstate_bus_resolver.sv
// Self-checking bench for fourstate_bus_resolver: directed test-plan steps followed
// by random stimulus, compared against a symbolic 4-state model with a latency queue.
module tb_fourstate_bus_resolver;
  localparam int W    = 4;
  localparam int NDRV = 2;
  localparam int PIPE = 2;
  localparam int CNTW = 2;
  localparam int CMAX = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [1:0]        mode;
  logic [NDRV*W-1:0] drv_d_b1;
  logic [NDRV*W-1:0] drv_d_b0;
  logic [NDRV-1:0]   drv_en_b1;
  logic [NDRV-1:0]   drv_en_b0;
  logic              clr_cnt;
  logic              out_valid;
  logic [W-1:0]      out_b1;
  logic [W-1:0]      out_b0;
  logic              conflict;
  logic [CNTW-1:0]   conflict_cnt;

  always #5 clk = ~clk;

  fourstate_bus_resolver #(.W(W), .NDRV(NDRV), .PIPE(PIPE), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
    .drv_d_b1(drv_d_b1), .drv_d_b0(drv_d_b0),
    .drv_en_b1(drv_en_b1), .drv_en_b0(drv_en_b0),
    .clr_cnt(clr_cnt), .out_valid(out_valid), .out_b1(out_b1), .out_b0(out_b0),
    .conflict(conflict), .conflict_cnt(conflict_cnt)
  );

  typedef enum int {L0, L1, LZ, LX} lv_t;
  typedef struct packed {
    logic         v;
    logic [W-1:0] b1;
    logic [W-1:0] b0;
    logic         c;
  } samp_t;

  samp_t exp_q[$];
  int    cnt_m;
  int    ntests;
  int    nfail;

  function automatic lv_t to_lv(input logic b1, input logic b0);
    case ({b1, b0})
      2'b00:   return L0;
      2'b01:   return L1;
      2'b10:   return LZ;
      default: return LX;
    endcase
  endfunction

  function automatic logic [1:0] from_lv(input lv_t v);
    case (v)
      L0:      return 2'b00;
      L1:      return 2'b01;
      LZ:      return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Reference: count driver contributions per bit and apply the net-type rules.
  function automatic samp_t model();
    samp_t s;
    int    n0, n1, nx;
    lv_t   e, d, c, r;
    bit    clash;
    clash = 1'b0;
    s     = '0;
    s.v   = in_valid;
    for (int i = 0; i < W; i++) begin
      n0 = 0; n1 = 0; nx = 0;
      for (int k = 0; k < NDRV; k++) begin
        e = to_lv(drv_en_b1[k], drv_en_b0[k]);
        d = to_lv(drv_d_b1[k*W+i], drv_d_b0[k*W+i]);
        if (e == L0) c = LZ;
        else if (e == L1) c = (d == L0 || d == L1) ? d : LX;
        else c = LX;
        if (c == L0) n0++;
        if (c == L1) n1++;
        if (c == LX) nx++;
      end
      if (mode == 2'b01) r = (n0 > 0) ? L0 : (nx > 0) ? LX : (n1 > 0) ? L1 : LZ;
      else if (mode == 2'b10) r = (n1 > 0) ? L1 : (nx > 0) ? LX : (n0 > 0) ? L0 : LZ;
      else if (n0 + n1 + nx == 0) r = LZ;
      else if (nx > 0 || (n0 > 0 && n1 > 0)) r = LX;
      else r = (n1 > 0) ? L1 : L0;
      {s.b1[i], s.b0[i]} = from_lv(r);
      if (n0 > 0 && n1 > 0) clash = 1'b1;
    end
    s.c = in_valid && clash && (mode != 2'b01) && (mode != 2'b10);
    return s;
  endfunction

  function automatic samp_t shown();
    samp_t r;
    r = {1'b0, 4'hF, 4'h0, 1'b0};
    if (exp_q.size() == PIPE) r = exp_q[0];
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: update the model at the rising edge, compare at the falling edge.
  task automatic cyc();
    samp_t disp;
    samp_t e;
    @(posedge clk);
    disp = shown();
    if (rst) begin
      exp_q.delete();
      cnt_m = 0;
    end else begin
      if (clr_cnt) cnt_m = 0;
      else if (disp.v && disp.c && cnt_m < CMAX) cnt_m++;
      exp_q.push_back(model());
      if (exp_q.size() > PIPE) void'(exp_q.pop_front());
    end
    @(negedge clk);
    e = shown();
    check("out_valid", 8'(out_valid), 8'(e.v));
    check("out_b1", 8'(out_b1), 8'(e.b1));
    check("out_b0", 8'(out_b0), 8'(e.b0));
    check("conflict", 8'(conflict), 8'(e.c));
    check("conflict_cnt", 8'(conflict_cnt), 8'(cnt_m));
  endtask

  task automatic set_drv(input int k, input logic [1:0] en, input logic [W-1:0] d1,
                         input logic [W-1:0] d0);
    drv_en_b1[k] = en[1];
    drv_en_b0[k] = en[0];
    drv_d_b1[k*W +: W] = d1;
    drv_d_b0[k*W +: W] = d0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    set_drv(0, 2'b00, 4'h0, 4'h0);
    set_drv(1, 2'b00, 4'h0, 4'h0);
  endtask

  task automatic rand_in();
    in_valid  = 1'($urandom);
    mode      = 2'($urandom);
    drv_d_b1  = 8'($urandom);
    drv_d_b0  = 8'($urandom);
    drv_en_b1 = 2'($urandom);
    drv_en_b0 = 2'($urandom);
    clr_cnt   = ($urandom_range(0, 15) == 0);
  endtask

  task automatic contend();
    in_valid = 1'b1;
    mode     = 2'b00;
    set_drv(0, 2'b01, 4'h0, 4'h1);
    set_drv(1, 2'b01, 4'h0, 4'h0);
  endtask

  initial begin
    ntests = 0;
    nfail  = 0;
    cnt_m  = 0;
    rst    = 1'b1;
    mode   = 2'b00;
    rand_in();

    repeat (3) begin
      rand_in();
      cyc();
    end
    check("rst_valid", 8'(out_valid), 8'h00);
    check("rst_b1", 8'(out_b1), 8'h0F);
    check("rst_b0", 8'(out_b0), 8'h00);
    check("rst_cnt", 8'(conflict_cnt), 8'h00);
    rst = 1'b0;
    idle();
    repeat (2) begin
      cyc();
      check("post_rst_valid", 8'(out_valid), 8'h00);
    end

    // Single tri driver, then all drivers disabled.
    in_valid = 1'b1;
    mode     = 2'b00;
    set_drv(0, 2'b01, 4'h0, 4'hA);
    cyc(); idle(); cyc();
    check("single_b1", 8'(out_b1), 8'h00);
    check("single_b0", 8'(out_b0), 8'h0A);
    in_valid = 1'b1;
    cyc(); idle(); cyc();
    check("allz_b1", 8'(out_b1), 8'h0F);
    check("allz_b0", 8'(out_b0), 8'h00);

    // Tri contention on bit 0.
    contend();
    cyc(); idle(); cyc();
    check("cont_b1", 8'(out_b1), 8'h01);
    check("cont_b0", 8'(out_b0), 8'h01);
    check("cont_flag", 8'(conflict), 8'h01);
    cyc();
    check("cont_cnt", 8'(conflict_cnt), 8'h01);

    // Same drivers under wand and wor.
    contend(); mode = 2'b01;
    cyc(); idle(); cyc();
    check("wand_b0", 8'(out_b0), 8'h00);
    check("wand_flag", 8'(conflict), 8'h00);
    contend(); mode = 2'b10;
    cyc(); idle(); cyc();
    check("wor_b1", 8'(out_b1), 8'h00);
    check("wor_b0", 8'(out_b0), 8'h01);
    cyc();
    check("wandwor_cnt", 8'(conflict_cnt), 8'h01);

    // Unknown enable, then a Z data bit on an enabled driver.
    in_valid = 1'b1; mode = 2'b00;
    set_drv(0, 2'b11, 4'h0, 4'hF);
    cyc(); idle(); cyc();
    check("enx_b1", 8'(out_b1), 8'h0F);
    check("enx_b0", 8'(out_b0), 8'h0F);
    in_valid = 1'b1;
    set_drv(0, 2'b01, 4'b0100, 4'b1011);
    cyc(); idle(); cyc();
    check("dz_b1", 8'(out_b1), 8'h04);
    check("dz_b0", 8'(out_b0), 8'h0F);

    // Counter saturation, clear racing an increment, reset with samples in flight.
    contend(); clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    repeat (7) cyc();
    check("sat_cnt", 8'(conflict_cnt), 8'(CMAX));
    clr_cnt = 1'b1;
    cyc();
    check("clr_vs_inc", 8'(conflict_cnt), 8'h00);
    clr_cnt = 1'b0;
    cyc(); cyc();
    rst = 1'b1; idle();
    cyc();
    rst = 1'b0;
    repeat (3) begin
      cyc();
      check("flush_valid", 8'(out_valid), 8'h00);
    end

    repeat (400) begin
      rand_in();
      rst = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rst = 1'b0;
    idle();
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
